// File: rtl/writeline_avalon.sv
// writeline_avalon: responder for the writeline do/done handshake; writes one 128-bit line as four 32-bit Avalon-MM beats.
// Defining WRITELINE_STALL_COUNT_EN adds a saturating stall_count output.
module writeline_avalon #(
  parameter int BURST_MODE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         writeline_do,
  output logic         writeline_done,
  input  logic [31:0]  writeline_address,
  input  logic [127:0] writeline_line,
  output logic [29:0]  avm_address,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  output logic [3:0]   avm_byteenable,
  output logic [2:0]   avm_burstcount,
  input  logic         avm_waitrequest
`ifdef WRITELINE_STALL_COUNT_EN
  ,
  output logic [15:0]  stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   beat;
  logic [27:0]  line_addr;
  logic [127:0] line_data;
  logic         beat_accept;
  logic         last_beat;

  // Byte-offset bits within the line carry no information for a full-line write.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^writeline_address[3:0];

  function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] idx);
    return line[{idx, 5'd0} +: 32];
  endfunction

  function automatic logic [29:0] beat_address(input logic [27:0] base, input logic [1:0] idx);
    if (BURST_MODE != 0)
      return {base, 2'b00};
    else
      return {base, idx};
  endfunction

  assign beat_accept = (state == WRITE) && !avm_waitrequest;
  assign last_beat   = (beat == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (writeline_do) state_nxt = WRITE;
      WRITE:   if (beat_accept && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: address/line are latched once and never re-sampled during the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= 2'd0;
      line_addr <= '0;
      line_data <= '0;
    end else begin
      if (state == IDLE && writeline_do) begin
        beat      <= 2'd0;
        line_addr <= writeline_address[31:4];
        line_data <= writeline_line;
      end else if (beat_accept) begin
        beat <= beat + 2'd1;
      end
    end
  end

  // Bus outputs are pure functions of registered state, so they hold steady through stalls.
  always_comb begin
    writeline_done = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    avm_burstcount = '0;
    case (state)
      WRITE: begin
        avm_write      = 1'b1;
        avm_address    = beat_address(line_addr, beat);
        avm_writedata  = word_sel(line_data, beat);
        avm_byteenable = 4'hF;
        avm_burstcount = (BURST_MODE != 0) ? 3'd4 : 3'd1;
      end
      DONE:    writeline_done = 1'b1;
      default: ;
    endcase
  end

`ifdef WRITELINE_STALL_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (avm_write && avm_waitrequest && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: doc/writeline_avalon.md
Name: writeline_avalon

Overview:
- Responder end of the writeline do/done protocol. Accepts one 128-bit cache line and writes it to memory over a 32-bit Avalon-MM master as four beats, then returns a one-cycle done pulse.
- Sits downstream of the writeline link stage in the memory path, at the boundary to the system bus.

Parameters:
BURST_MODE, 1, 1 = one 4-beat burst (burstcount 4, address held); 0 = four single writes (burstcount 1, address incremented per word)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
writeline_do  input  1  request; held high with address/line stable until writeline_done seen
writeline_done  output  1  one-cycle completion pulse
writeline_address  input  32  line byte address; bits [3:0] ignored
writeline_line  input  128  line data; word i = bits [32*i+31:32*i]
avm_address  output  30  word address (byte address [31:2])
avm_write  output  1  write strobe
avm_writedata  output  32  beat data
avm_byteenable  output  4  byte enables
avm_burstcount  output  3  burst length
avm_waitrequest  input  1  slave stall

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0; beat counter 0; latched address/line cleared.
- States: IDLE, WRITE, DONE.
- IDLE: writeline_do=1 -> latch address[31:4] and line; beat=0; go to WRITE. First avm_write appears the next cycle.
- WRITE:
  - avm_write=1, avm_byteenable=4'hF, avm_writedata=word[beat].
  - BURST_MODE=1: avm_address={addr[31:4],2'b00} for all beats; avm_burstcount=4.
  - BURST_MODE=0: avm_address={addr[31:4],beat[1:0]}; avm_burstcount=1.
  - A beat is accepted when avm_write && !avm_waitrequest; beat increments on acceptance.
  - Acceptance of beat 3 -> go to DONE; avm_write drops in the same transition.
- DONE: writeline_done=1 for exactly one cycle; outputs otherwise 0; go to IDLE.
- Latency with no stalls: do sampled at cycle 0, beats in cycles 1-4, done in cycle 5.
- Stalls: while avm_waitrequest=1, all avm_* outputs stay stable indefinitely. Each stall cycle extends latency by one.
- writeline_do is ignored in WRITE and DONE. Inputs are not re-sampled; the latched copy is authoritative.
- Back-to-back requests: the requester drops do the cycle after done. If do is high again in the IDLE cycle following DONE, that is a new request and is accepted (minimum one idle cycle between bursts).
- Reset during WRITE: bus cycle abandoned immediately, no done pulse; the requester is reset by the same rst.
- avm_waitrequest is ignored when avm_write=0.
- writeline_done never asserts outside DONE, and never on two consecutive cycles.

Optional Feature:
- Macro: WRITELINE_STALL_COUNT_EN.
- Defined:
  - Adds output port stall_count [15:0].
  - Counts cycles with avm_write && avm_waitrequest, saturating at 16'hFFFF.
  - Cleared by rst only; never wraps.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- BURST_MODE=1, address=32'h0000_1234, line=128'h44444444_33333333_22222222_11111111, waitrequest=0 -> avm_address=30'h48C for cycles 1-4; burstcount=4; writedata 11111111, 22222222, 33333333, 44444444; writeline_done=1 only in cycle 5.
- BURST_MODE=0, same stimulus -> avm_address 30'h48C, 48D, 48E, 48F; burstcount=1 each beat; done in cycle 5.
- Hold waitrequest=1 for 3 cycles during beat 1 -> beat-1 data/address stable for 4 cycles; done in cycle 8. With macro defined, stall_count=3.
- Two requests back-to-back (do re-asserted the cycle after done) -> second burst starts 2 cycles after first done; exactly two done pulses.
- Assert rst for one cycle during beat 2 -> avm_write=0 immediately; no done pulse; a fresh request then completes normally with 4 beats.
- Toggle writeline_address/line during WRITE -> emitted data/addresses match the values latched at acceptance.
